// File: rtl/test_gate_debounced_if.sv
// Switch-bank and light-bank signals of the debounced test gate, with modports
// for the driving side (master) and the gate itself (slave).
interface test_gate_debounced_if #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] A;
  logic [1:0]       MODE;
  logic             Y;
  logic             Y_VALID;
  logic [CNT_W-1:0] EDGES;

  modport master (output A, MODE, input  Y, Y_VALID, EDGES);
  modport slave  (input  A, MODE, output Y, Y_VALID, EDGES);
endinterface

// File: rtl/test_gate_debounced.sv
// Synchronised, debounced WIDTH-input reduction gate (NOR/OR/NAND/XOR) with a
// registered output, a settled flag and a wrapping rising-edge counter.
module test_gate_debounced #(
  parameter int WIDTH    = 2,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input logic             CLK,
  input logic             RST_N,
  test_gate_debounced_if.slave bus
);

  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  typedef enum logic {STABLE = 1'b0, SETTLE = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] s1, s2;
  logic [WIDTH-1:0] stab, stab_nxt;
  logic [WIDTH-1:0] cand, cand_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [1:0]       m1, m2;
  logic             f;
  logic             valid_nxt;
  logic [CNT_W-1:0] edges_nxt;

  // NOTE: every flop uses non-blocking assignment so all registers update from
  // the same pre-edge values; blocking here would chain s1 straight into s2.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1          <= '0;
      s2          <= '0;
      m1          <= '0;
      m2          <= '0;
      state       <= STABLE;
      stab        <= '0;
      cand        <= '0;
      cnt         <= '0;
      bus.Y       <= 1'b0;
      bus.Y_VALID <= 1'b0;
      bus.EDGES   <= '0;
    end else begin
      s1          <= bus.A;
      s2          <= s1;
      m1          <= bus.MODE;
      m2          <= m1;
      state       <= state_nxt;
      stab        <= stab_nxt;
      cand        <= cand_nxt;
      cnt         <= cnt_nxt;
      bus.Y       <= f;
      bus.Y_VALID <= valid_nxt;
      bus.EDGES   <= edges_nxt;
    end
  end

  // NOTE: each combinational output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    stab_nxt  = stab;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    case (state)
      STABLE: begin
        if (s2 != stab) begin
          cand_nxt  = s2;
          cnt_nxt   = '0;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        // A glitch restarts the window; a bounce back settles to the old value.
        if (s2 != cand) begin
          cand_nxt = s2;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          stab_nxt  = cand;
          state_nxt = STABLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = STABLE;
    endcase
  end

  always_comb begin
    f = 1'b0;
    case (m2)
      2'd0:    f = ~|stab;
      2'd1:    f =  |stab;
      2'd2:    f = ~&stab;
      default: f =  ^stab;
    endcase
    valid_nxt = (state == STABLE) && (s2 == stab);
    edges_nxt = bus.EDGES + CNT_W'(f & ~bus.Y);
  end

endmodule

// File: tb/tb_test_gate_debounced.sv
// Scoreboard bench for test_gate_debounced: a run-length debounce model predicts
// every cycle's outputs, plus directed timing checks from the test plan.
module tb_test_gate_debounced;

  localparam int WIDTH    = 2;
  localparam int DEBOUNCE = 4;

  logic CLK;
  logic RST_N;
  bit   clk_run = 1'b1;

  test_gate_debounced_if #(.WIDTH(WIDTH), .CNT_W(4)) bus ();
  test_gate_debounced_if #(.WIDTH(WIDTH), .CNT_W(2)) bus2 ();

  assign bus2.A    = bus.A;
  assign bus2.MODE = bus.MODE;

  test_gate_debounced #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .CNT_W(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  test_gate_debounced #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .CNT_W(2)) dut_wrap (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus2)
  );

  initial begin
    CLK = 1'b0;
    forever begin
      #5;
      if (clk_run) CLK = ~CLK;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs seen through a two-sample delay; a new value is
  // accepted once it has been seen for DEBOUNCE+1 consecutive samples.
  typedef struct {
    logic y;
    logic v;
    int   e;
  } exp_t;

  exp_t       sb[$];
  logic [1:0] ms1, ms2, mm1, mm2, mstab, mlast;
  int         mrun;
  bit         msettling;
  logic       my;
  int         me;

  function automatic logic ref_f(input logic [1:0] v, input logic [1:0] mode);
    int ones;
    ones = $countones(v);
    case (mode)
      2'd0:    return ones == 0;
      2'd1:    return ones != 0;
      2'd2:    return ones != WIDTH;
      default: return (ones % 2) == 1;
    endcase
  endfunction

  task automatic model_reset();
    ms1 = '0; ms2 = '0; mm1 = '0; mm2 = '0;
    mstab = '0; mlast = '0; mrun = 1; msettling = 1'b0;
    my = 1'b0; me = 0;
    sb.delete();
  endtask

  task automatic model_step();
    exp_t x;
    logic fv;
    fv  = ref_f(mstab, mm2);
    x.y = fv;
    x.v = !msettling && (ms2 == mstab);
    me  = me + ((fv && !my) ? 1 : 0);
    x.e = me;
    my  = fv;
    sb.push_back(x);
    if (ms2 == mlast) mrun++;
    else mrun = 1;
    mlast = ms2;
    if (!msettling) begin
      if (ms2 != mstab) msettling = 1'b1;
    end else if (mrun == DEBOUNCE + 1) begin
      mstab     = ms2;
      msettling = 1'b0;
    end
    ms2 = ms1; ms1 = bus.A;
    mm2 = mm1; mm1 = bus.MODE;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge CLK);
      if (RST_N) model_step();
      else model_reset();
    end
  end

  initial begin
    exp_t x;
    forever begin
      @(negedge CLK);
      if (RST_N && sb.size() > 0) begin
        x = sb.pop_front();
        check("sb_y",          32'(bus.Y),       32'(x.y));
        check("sb_valid",      32'(bus.Y_VALID), 32'(x.v));
        check("sb_edges",      32'(bus.EDGES),   x.e % 16);
        check("sb_y_wrap",     32'(bus2.Y),      32'(x.y));
        check("sb_edges_wrap", 32'(bus2.EDGES),  x.e % 4);
        check("sb_depth",      sb.size(),        0);
      end
    end
  end

  task automatic expect_out(input string tag, input logic y, input logic v, input int e);
    check({tag, "_y"},     32'(bus.Y),       32'(y));
    check({tag, "_valid"}, 32'(bus.Y_VALID), 32'(v));
    check({tag, "_edges"}, 32'(bus.EDGES),   e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    int exp10[4] = '{0, 1, 1, 1};
    int exp11[4] = '{0, 1, 0, 0};
    int low_cnt;

    RST_N    = 1'b0;
    bus.A    = 2'b00;
    bus.MODE = 2'd0;
    wait_cycles(3);
    expect_out("in_reset", 1'b0, 1'b0, 0);
    check("in_reset_edges_wrap", 32'(bus2.EDGES), 0);
    RST_N = 1'b1;
    @(negedge CLK);
    expect_out("post_reset", 1'b1, 1'b1, 1);

    // Settled step 00 -> 01: valid drops at edge 3, Y falls at edge 8.
    bus.A = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      check("step_y",     32'(bus.Y),       (k < 8) ? 1 : 0);
      check("step_valid", 32'(bus.Y_VALID), (k < 3 || k == 8) ? 1 : 0);
      check("step_edges", 32'(bus.EDGES),   1);
    end

    bus.A = 2'b00;
    wait_cycles(10);
    expect_out("back_to_00", 1'b1, 1'b1, 2);

    // Two-cycle glitch: Y must hold, valid dips for a while and recovers.
    bus.A = 2'b01;
    wait_cycles(2);
    bus.A = 2'b00;
    low_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge CLK);
      check("glitch_y", 32'(bus.Y), 1);
      if (!bus.Y_VALID) low_cnt++;
    end
    check("glitch_low_ge4", (low_cnt >= 4) ? 1 : 0, 1);
    expect_out("glitch_end", 1'b1, 1'b1, 2);

    bus.A = 2'b10;
    wait_cycles(10);
    for (int m = 0; m < 4; m++) begin
      bus.MODE = 2'(m);
      wait_cycles(3);
      check("mode_a10", 32'(bus.Y), exp10[m]);
    end
    bus.A = 2'b11;
    wait_cycles(10);
    for (int m = 0; m < 4; m++) begin
      bus.MODE = 2'(m);
      wait_cycles(3);
      check("mode_a11", 32'(bus.Y), exp11[m]);
    end

    // Five rising edges from reset: narrow counter wraps to 1.
    RST_N    = 1'b0;
    bus.A    = 2'b00;
    bus.MODE = 2'd0;
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.A = 2'b01;
      wait_cycles(10);
      bus.A = 2'b00;
      wait_cycles(10);
    end
    check("wrap_edges_narrow", 32'(bus2.EDGES), 1);
    check("wrap_edges_wide",   32'(bus.EDGES),  5);

    // Async reset in the middle of settling, with the clock stopped.
    bus.A = 2'b01;
    wait_cycles(4);
    clk_run = 1'b0;
    #2 RST_N = 1'b0;
    #1;
    expect_out("async_reset", 1'b0, 1'b0, 0);
    check("async_reset_edges_wrap", 32'(bus2.EDGES), 0);
    model_reset();
    #5 RST_N = 1'b1;
    #1 clk_run = 1'b1;
    for (int k = 1; k <= 1 + DEBOUNCE + 3; k++) begin
      @(negedge CLK);
      if (k == 1) expect_out("rerelease_e1", 1'b1, 1'b1, 1);
      if (k == DEBOUNCE + 3) check("rerelease_settling_valid", 32'(bus.Y_VALID), 0);
      if (k == DEBOUNCE + 4) begin
        check("rerelease_y",     32'(bus.Y),       0);
        check("rerelease_valid", 32'(bus.Y_VALID), 1);
      end
    end

    for (int i = 0; i < 40; i++) begin
      bus.A = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) bus.MODE = 2'($urandom_range(0, 3));
      wait_cycles(int'($urandom_range(1, 9)));
    end
    wait_cycles(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/test_gate_debounced.md
# test_gate_debounced

Parametrised, sequential successor to the two-input NOR test gate. It samples a WIDTH-bit switch bank, synchronises and debounces it, applies a run-time selectable reduction function (NOR/OR/NAND/XOR), and registers the result together with a validity flag and a rising-edge counter. It sits between an `MCPNR_SWITCHES` bank and an `MCPNR_LIGHTS` bank in place-and-route test tops. WIDTH=2 with MODE=0 reproduces the old NOR function after the pipeline delay.

## Interface
- Clock and reset: one clock `CLK`; reset `RST_N` is asynchronous and active-low.
- `WIDTH`, default 2: input count, ≥2.
- `DEBOUNCE`, default 4: consecutive stable cycles required, ≥1.
- `CNT_W`, default 4: `EDGES` width, ≥1.
- `CLK`  in  1: clock.
- `RST_N`  in  1: async active-low reset.
- `A`  in  WIDTH: switch inputs, asynchronous to `CLK`.
- `MODE`  in  2: 0=NOR, 1=OR, 2=NAND, 3=XOR (reduction over all WIDTH bits).
- `Y`  out  1: registered function output.
- `Y_VALID`  out  1: high when `Y` reflects a settled input.
- `EDGES`  out  CNT_W: count of `Y` 0→1 transitions, modulo 2^CNT_W.

## Operation
- Reset (async, while `RST_N`=0): all state is cleared immediately, with no clock required. Sync flops=0, `stab`=0, `cand`=0, `cnt`=0, FSM=STABLE, `MODE` sync=0, `Y`=0, `Y_VALID`=0, `EDGES`=0.
- Synchroniser: 2-flop chain `s1`←`A`, `s2`←`s1`. `MODE` has its own 2-flop chain (`m2`) and is not debounced.
- Debounce FSM. Counter width is max(1, clog2(DEBOUNCE)).
  - STABLE: if `s2`≠`stab`, then `cand`←`s2`, `cnt`←0, go to SETTLE. Otherwise hold.
  - SETTLE, checked in this priority order:
    - `s2`≠`cand`: `cand`←`s2`, `cnt`←0, stay in SETTLE.
    - `cnt`==DEBOUNCE−1: `stab`←`cand`, go to STABLE.
    - Otherwise: `cnt`←`cnt`+1.
  - A bounce back to the old value settles to an unchanged `stab`. In that case `Y` does not change, but `Y_VALID` still dips.
- Output stage, every cycle:
  - `Y`←f(`stab`, `m2`).
  - `Y_VALID`←(FSM==STABLE)&&(`s2`==`stab`).
  - `EDGES`←`EDGES`+(f(`stab`,`m2`)&~`Y`), wrapping with no saturation.
- A 0→1 transition of `Y` right after reset counts as an edge.
- A `MODE` change alters `Y` without affecting `Y_VALID`. It counts toward `EDGES` if `Y` rises.

## Timing
- Edge k means the k-th rising `CLK` after `A` changes, with setup met before edge 1.
- Edge 1: `s1` captures the change. Edge 2: `s2` captures it.
- Edge 3: FSM enters SETTLE and `Y_VALID` falls.
- Edge 3+DEBOUNCE: `stab` updates.
- Edge 4+DEBOUNCE: `Y`, `Y_VALID`=1 and `EDGES` update. This is 8 cycles at the default DEBOUNCE.
- Glitch rule: any change of `s2` during SETTLE restarts the count.
- `MODE`→`Y` latency: 3 edges.
- After reset release with steady inputs: `Y` and `Y_VALID` are valid at edge 1.
- Reset asserted mid-SETTLE: outputs are 0 at once. After release, settling restarts from `stab`=0.

## Test plan
- Reset, defaults, `A`=00, `MODE`=0: during reset `Y`=0, `Y_VALID`=0, `EDGES`=0. One edge after release: `Y`=1, `Y_VALID`=1, `EDGES`=1.
- `A` 00→01 (DEBOUNCE=4): `Y_VALID`=0 from edge 3. At edge 8 `Y`=0 and `Y_VALID`=1. `Y` stays 1 through edge 7. `EDGES` unchanged.
- Glitch: `A` 00→01 for 2 cycles, then back to 00: `Y` holds 1 throughout, `EDGES` unchanged, `Y_VALID` low for at least 4 cycles, then high.
- MODE sweep with settled `A`=10, then `A`=11:
  - `A`=10: `Y` = 0/1/1/1 for MODE 0/1/2/3.
  - `A`=11: `Y` = 0/1/0/0 for MODE 0/1/2/3.
  - Each `MODE` change is visible 3 edges later.
- Wrap: CNT_W=2, drive 5 settled `Y` rising edges: `EDGES`=1.
- Async reset mid-SETTLE with no clock running: `Y`, `Y_VALID`, `EDGES` read 0 immediately. After release with `A`=01 held: `Y`=0, `Y_VALID`=1 at edge 1+DEBOUNCE+3.
